// File: rtl/uart_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_param : parametrised UART (tick generator, TX and RX in one module)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50mhz,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 write_enable,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int   c_os_div   = CLK_FREQ / (16 * BAUD);
  localparam int   c_os_w     = (c_os_div > 1) ? $clog2(c_os_div) : 1;
  localparam logic c_has_par  = (PARITY != 0);
  localparam logic c_odd      = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- tick gen
  logic [c_os_w-1:0] r_os_cnt;
  logic              w_os_tick;

  assign w_os_tick = (r_os_cnt == c_os_w'(c_os_div - 1));

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst)            r_os_cnt <= '0;
    else if (w_os_tick) r_os_cnt <= '0;
    else                r_os_cnt <= r_os_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- transmitter
  state_t               r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_armed;
  logic [3:0]           r_tx_tick_cnt;
  logic [3:0]           r_tx_bit_cnt;
  logic                 r_tx_stop_cnt;

  // r_tx_armed stays low between the latch and the first tick so the start
  // bit is aligned to the tick grid and lasts a full 16 ticks.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_tx_state    <= ST_IDLE;
      tx            <= 1'b1;
      tx_busy       <= 1'b0;
      r_tx_shift    <= '0;
      r_tx_par      <= 1'b0;
      r_tx_armed    <= 1'b0;
      r_tx_tick_cnt <= '0;
      r_tx_bit_cnt  <= '0;
      r_tx_stop_cnt <= 1'b0;
    end else if (r_tx_state == ST_IDLE) begin
      tx <= 1'b1;
      if (write_enable) begin
        r_tx_shift <= data_in;
        r_tx_par   <= (^data_in) ^ c_odd;
        tx_busy    <= 1'b1;
        r_tx_armed <= 1'b0;
        r_tx_state <= ST_START;
      end
    end else if (w_os_tick) begin
      if (!r_tx_armed) begin
        r_tx_armed    <= 1'b1;
        r_tx_tick_cnt <= '0;
        tx            <= 1'b0;
      end else if (r_tx_tick_cnt != 4'd15) begin
        r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
      end else begin
        r_tx_tick_cnt <= '0;
        case (r_tx_state)
          ST_START: begin
            tx           <= r_tx_shift[0];
            r_tx_shift   <= r_tx_shift >> 1;
            r_tx_bit_cnt <= '0;
            r_tx_state   <= ST_DATA;
          end
          ST_DATA: begin
            if (r_tx_bit_cnt == 4'(DATA_BITS - 1)) begin
              if (c_has_par) begin
                tx         <= r_tx_par;
                r_tx_state <= ST_PARITY;
              end else begin
                tx            <= 1'b1;
                r_tx_stop_cnt <= 1'b0;
                r_tx_state    <= ST_STOP;
              end
            end else begin
              tx           <= r_tx_shift[0];
              r_tx_shift   <= r_tx_shift >> 1;
              r_tx_bit_cnt <= r_tx_bit_cnt + 4'd1;
            end
          end
          ST_PARITY: begin
            tx            <= 1'b1;
            r_tx_stop_cnt <= 1'b0;
            r_tx_state    <= ST_STOP;
          end
          ST_STOP: begin
            if (r_tx_stop_cnt == 1'(STOP_BITS - 1)) begin
              tx_busy    <= 1'b0;
              r_tx_armed <= 1'b0;
              r_tx_state <= ST_IDLE;
            end else begin
              r_tx_stop_cnt <= 1'b1;
            end
          end
          default: r_tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- receiver
  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_rx_state;
  logic [3:0]           r_rx_cnt;
  logic [3:0]           r_rx_bit_cnt;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_perr;
  logic                 w_rx_done;

  assign w_rx_done = (r_rx_state == ST_STOP) && w_os_tick && (r_rx_cnt == 4'd15);

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_rx_state   <= ST_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit_cnt <= '0;
      r_rx_shift   <= '0;
      r_rx_perr    <= 1'b0;
      data_out     <= '0;
      ready        <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (ready_clr) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end
      if (w_os_tick) begin
        case (r_rx_state)
          ST_IDLE: begin
            if (!r_rx_s) begin
              r_rx_cnt   <= '0;
              r_rx_state <= ST_START;
            end
          end
          ST_START: begin
            if (r_rx_cnt == 4'd7) begin
              r_rx_cnt     <= '0;
              r_rx_bit_cnt <= '0;
              r_rx_state   <= r_rx_s ? ST_IDLE : ST_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + 4'd1;
            end
          end
          ST_DATA: begin
            if (r_rx_cnt == 4'd15) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
              if (r_rx_bit_cnt == 4'(DATA_BITS - 1))
                r_rx_state <= c_has_par ? ST_PARITY : ST_STOP;
              else
                r_rx_bit_cnt <= r_rx_bit_cnt + 4'd1;
            end else begin
              r_rx_cnt <= r_rx_cnt + 4'd1;
            end
          end
          ST_PARITY: begin
            if (r_rx_cnt == 4'd15) begin
              r_rx_cnt   <= '0;
              r_rx_perr  <= (^r_rx_shift) ^ r_rx_s ^ c_odd;
              r_rx_state <= ST_STOP;
            end else begin
              r_rx_cnt <= r_rx_cnt + 4'd1;
            end
          end
          ST_STOP: begin
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
            if (r_rx_cnt == 4'd15) begin
              r_rx_cnt   <= '0;
              r_rx_state <= ST_IDLE;
              data_out   <= r_rx_shift;
              parity_err <= c_has_par && r_rx_perr;
              frame_err  <= !r_rx_s;
              ready      <= 1'b1;
              if (ready && !ready_clr) overrun <= 1'b1;
            end else begin
              r_rx_cnt <= r_rx_cnt + 4'd1;
            end
          end
          default: r_rx_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
